// File: rtl/i2s_audio_capture.sv
// ---------------------------------------------------------------------------
// i2s_audio_capture
//
// I2S receive path for the line-in ADC. It derives the ADC master, bit and
// left/right clocks from one free-running 9-bit counter and shifts in 16-bit
// stereo words from the ADC data line. Each completed stereo pair lands in a
// single-entry valid/ready output register. A sticky overflow flag records
// that a pair was replaced before it was consumed.
//
// Frame layout (one frame = 512 clk = 32 sck):
//   cnt[8:4] is the sck period index; cnt[3:0]==7 is the sck rising edge.
//   Because of the I2S one-bit delay, slot s = cnt[8:4]-1 (mod 32).
//   Left bits come in at cnt = 23, 39, ..., 263.
//   Right bits come in at cnt = 279, ..., 503, and at cnt = 7 of the next frame.
//
// Ports:
//   clk           in   100 MHz system clock
//   rst           in   asynchronous active-high reset
//   adc_mclk      out  clk/4 master clock   (cnt[1], registered)
//   adc_sck       out  clk/16 bit clock     (cnt[3], registered)
//   adc_lrck      out  clk/512 word clock   (cnt[8], registered; low = left)
//   adc_sdout     in   serial data from ADC, MSB first
//   sample_left   out  last completed left word (two's complement)
//   sample_right  out  last completed right word (two's complement)
//   sample_valid  out  pair in sample_left/right not yet consumed
//   sample_ready  in   consumer takes the pair at this edge when valid
//   overflow      out  sticky: an unconsumed pair was overwritten
// ---------------------------------------------------------------------------
module i2s_audio_capture (
    input  logic        clk,
    input  logic        rst,
    output logic        adc_mclk,
    output logic        adc_sck,
    output logic        adc_lrck,
    input  logic        adc_sdout,
    output logic [15:0] sample_left,
    output logic [15:0] sample_right,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overflow
);

    // Frame position and derived clocks
    logic [8:0]  r_cnt;
    logic        r_mclk;
    logic        r_sck;
    logic        r_lrck;

    // Deserialiser state
    logic [15:0] r_shift_left;
    logic [15:0] r_shift_right;
    logic        r_primed;

    // Output register
    logic [15:0] r_out_left;
    logic [15:0] r_out_right;
    logic        r_valid;
    logic        r_overflow;

    // Decode of the current counter position
    logic        w_bit_edge;
    logic        w_in_right;
    logic        w_take_left;
    logic        w_take_right;
    logic        w_complete;
    logic        w_prime_pt;
    logic        w_load;

    // A data bit is taken on every sck rising edge, which is the clk edge
    // that ends a cycle with cnt[3:0]==7.
    assign w_bit_edge   = (r_cnt[3:0] == 4'd7);

    // Slot s = cnt[8:4]-1 (mod 32) is in the right half (s >= 16) when
    // cnt[8:4] is 17..31, or 0 (the right LSB wraps into the next frame).
    assign w_in_right   = (r_cnt[8:4] == 5'd0) || (r_cnt[8:4] > 5'd16);

    assign w_take_left  = w_bit_edge && !w_in_right;
    assign w_take_right = w_bit_edge &&  w_in_right;

    // Right LSB sample: the whole stereo pair is now complete.
    assign w_complete   = (r_cnt == 9'd7);

    // Left LSB sample. After this point the shift registers hold real frame
    // data, so the following completion is the first one worth presenting.
    assign w_prime_pt   = (r_cnt == 9'd263);

    assign w_load       = w_complete && r_primed;

    // -----------------------------------------------------------------------
    // Counter and clock outputs. The outputs are registered copies of the
    // counter bits, so they lag cnt by one cycle. Bit timing is decoded from
    // cnt directly, so this lag never affects capture.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 9'd0;
            r_mclk <= 1'b0;
            r_sck  <= 1'b0;
            r_lrck <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 9'd1;
            r_mclk <= r_cnt[1];
            r_sck  <= r_cnt[3];
            r_lrck <= r_cnt[8];
        end
    end

    // -----------------------------------------------------------------------
    // Deserialiser. Each word shifts in MSB first. After 16 bits the word is
    // left-justified in its register, with no extra alignment step.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_left  <= 16'd0;
            r_shift_right <= 16'd0;
            r_primed      <= 1'b0;
        end else begin
            if (w_take_left)
                r_shift_left  <= {r_shift_left[14:0], adc_sdout};
            if (w_take_right)
                r_shift_right <= {r_shift_right[14:0], adc_sdout};
            if (w_prime_pt)
                r_primed      <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Single-entry output register.
    // A completion always loads the pair, so the newest pair wins. If it
    // replaces a pair that is still valid and is not being accepted at this
    // edge, the overwrite is recorded in the sticky overflow flag. A
    // completion that coincides with ready counts as a clean hand-off. With
    // no completion, ready only matters while valid is high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_left  <= 16'd0;
            r_out_right <= 16'd0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_left  <= r_shift_left;
                // The right LSB is arriving on this very edge, so splice it
                // in directly instead of waiting a cycle for the shifter.
                r_out_right <= {r_shift_right[14:0], adc_sdout};
                r_valid     <= 1'b1;
                if (r_valid && !sample_ready)
                    r_overflow <= 1'b1;
            end else if (r_valid && sample_ready) begin
                r_valid     <= 1'b0;
            end
        end
    end

    assign adc_mclk     = r_mclk;
    assign adc_sck      = r_sck;
    assign adc_lrck     = r_lrck;
    assign sample_left  = r_out_left;
    assign sample_right = r_out_right;
    assign sample_valid = r_valid;
    assign overflow     = r_overflow;

endmodule
